// File: rtl/mbr_arbiter_if.sv
// -----------------------------------------------------------------------------
// mbr_arbiter_if
// Bus bundle between the MBR arbiter, its two requesters, the MBR and memory.
//   Port 0 (fetch):   req0, we0, addr0, wdata0 -> ack0
//   Port 1 (execute): req1, we1, addr1, wdata1 -> ack1
//   Shared result:    rdata (current MBR contents)
//   MBR side:         mbr_we, mbr_in -> ; mbr_out <-
//   Memory side:      mem_addr, mem_rd, mem_wr, mem_wdata -> ; mem_rdata <-
//   Status:           busy, gnt_id
// Modports: slave = arbiter side, master = requester/environment side.
// -----------------------------------------------------------------------------
interface mbr_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req0, we0, ack0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          req1, we1, ack1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic [DW-1:0] rdata;
  logic          mbr_we;
  logic [DW-1:0] mbr_in, mbr_out;
  logic [AW-1:0] mem_addr;
  logic          mem_rd, mem_wr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, gnt_id;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mbr_out, mem_rdata,
    output ack0, ack1, rdata, mbr_we, mbr_in,
    output mem_addr, mem_rd, mem_wr, mem_wdata, busy, gnt_id
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mbr_out, mem_rdata,
    input  ack0, ack1, rdata, mbr_we, mbr_in,
    input  mem_addr, mem_rd, mem_wr, mem_wdata, busy, gnt_id
  );
endinterface

// File: rtl/mbr_arbiter.sv
// -----------------------------------------------------------------------------
// mbr_arbiter
// Shares one memory buffer register (MBR) and one memory port between an
// instruction-fetch requester (port 0) and a data/execute requester (port 1).
// A grant latches the winner's address/direction/write data, then walks
// IDLE -> LOAD -> ACCESS (MEM_LAT cycles) -> DONE, acking the winner in DONE.
//
// Ports:
//   mbr_arbiter_clk  rising-edge clock
//   mbr_arbiter_rst  synchronous active-high reset
//   bus              mbr_arbiter_if.slave (requests, acks, MBR and memory)
//
// Parameters: AW address width, DW data width, MEM_LAT strobe cycles (1..15).
//
// Build option: define MBR_ARB_RR_EN for round-robin tie breaking; otherwise
// port 0 has fixed priority.
// -----------------------------------------------------------------------------
module mbr_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int MEM_LAT = 2
) (
  input  logic           mbr_arbiter_clk,
  input  logic           mbr_arbiter_rst,
  mbr_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, LOAD, ACCESS, DONE} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  state_t      state_q, state_d;
  logic [3:0]  lat_cnt_q, lat_cnt_d;
  logic        gnt_id_q, gnt_id_d;
  req_t        cur_q, cur_d;

  logic [1:0]  req_v;
  req_t        req_p [2];
  logic        win;

  assign req_v    = {bus.req1, bus.req0};
  assign req_p[0] = '{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};
  assign req_p[1] = '{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1};

  // Winner is only meaningful when at least one request is up.
`ifdef MBR_ARB_RR_EN
  // On a tie, the port that did not win last time goes next.
  assign win = (req_v == 2'b11) ? ~gnt_id_q : req_v[1];
`else
  assign win = ~req_v[0];
`endif

  always_ff @(posedge mbr_arbiter_clk) begin
    if (mbr_arbiter_rst) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      gnt_id_q  <= 1'b1;
      cur_q     <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      gnt_id_q  <= gnt_id_d;
      cur_q     <= cur_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    gnt_id_d  = gnt_id_q;
    cur_d     = cur_q;
    unique case (state_q)
      IDLE: begin
        if (|req_v) begin
          gnt_id_d = win;
          cur_d    = req_p[win];
          state_d  = LOAD;
        end
      end
      LOAD: begin
        lat_cnt_d = 4'(MEM_LAT - 1);
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (lat_cnt_q == '0) state_d = DONE;
        else                 lat_cnt_d = lat_cnt_q - 4'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state only; the data paths (mbr_in,
  // rdata, mem_wdata) are the only combinational pass-throughs.
  logic in_load, in_access, last_access;
  assign in_load     = (state_q == LOAD);
  assign in_access   = (state_q == ACCESS);
  assign last_access = in_access && (lat_cnt_q == '0);

  assign bus.ack0      = (state_q == DONE) && !gnt_id_q;
  assign bus.ack1      = (state_q == DONE) &&  gnt_id_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.gnt_id    = gnt_id_q;
  assign bus.mem_addr  = cur_q.addr;
  assign bus.mem_rd    = in_access && !cur_q.we;
  assign bus.mem_wr    = in_access &&  cur_q.we;
  // Writes stage data into the MBR in LOAD; reads capture memory on the
  // final ACCESS cycle so the new value is visible in DONE.
  assign bus.mbr_we    = (in_load && cur_q.we) || (last_access && !cur_q.we);
  assign bus.mbr_in    = in_load   ? cur_q.wdata   :
                         in_access ? bus.mem_rdata : '0;
  assign bus.rdata     = bus.mbr_out;
  assign bus.mem_wdata = bus.mbr_out;

endmodule

// File: tb/tb_mbr_arbiter.sv
module tb_mbr_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mbr_arbiter_if #(.AW(AW), .DW(DW)) bus0 ();
  mbr_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();

  mbr_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(2)) dut0 (
    .mbr_arbiter_clk(clk), .mbr_arbiter_rst(rst), .bus(bus0.slave));
  mbr_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) dut1 (
    .mbr_arbiter_clk(clk), .mbr_arbiter_rst(rst), .bus(bus1.slave));

  // MBR models (not touched by reset) and memory returning addr ^ 0x4A.
  logic [DW-1:0] mbr0_q = '0;
  logic [DW-1:0] mbr1_q = '0;
  always @(posedge clk) if (bus0.mbr_we) mbr0_q <= bus0.mbr_in;
  always @(posedge clk) if (bus1.mbr_we) mbr1_q <= bus1.mbr_in;
  assign bus0.mbr_out   = mbr0_q;
  assign bus1.mbr_out   = mbr1_q;
  assign bus0.mem_rdata = bus0.mem_addr ^ 8'h4A;
  assign bus1.mem_rdata = bus1.mem_addr ^ 8'h4A;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for an ack on bus0; returns port and number of edges taken.
  task automatic wait_ack(output int port, output int n);
    port = -1;
    n    = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus0.ack0 || bus0.ack1) begin
        n    = i;
        port = bus0.ack1 ? 1 : 0;
        chk("one_ack", {31'd0, bus0.ack0 & bus0.ack1}, 32'd0);
        break;
      end
    end
    if (port < 0) begin
      checks++;
      failures++;
      $error("FAIL ack_timeout observed=none expected=ack within 20 cycles");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  int p, n, rdcnt, ackat;
  logic [DW-1:0] rd1;

  initial begin
    rst = 1'b1;
    {bus0.req0, bus0.we0, bus0.addr0, bus0.wdata0} = '0;
    {bus0.req1, bus0.we1, bus0.addr1, bus0.wdata1} = '0;
    {bus1.req0, bus1.we0, bus1.addr0, bus1.wdata0} = '0;
    {bus1.req1, bus1.we1, bus1.addr1, bus1.wdata1} = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_busy",   bus0.busy,     0);
    chk("rst_ack",    {bus0.ack1, bus0.ack0}, 0);
    chk("rst_strobe", {bus0.mem_rd, bus0.mem_wr, bus0.mbr_we}, 0);
    chk("rst_addr",   bus0.mem_addr, 0);
    chk("rst_gnt",    bus0.gnt_id,   1);
    chk("rst_busy1",  bus1.busy,     0);
    rst = 1'b0;
    tick();

    // Port 0 read of 0x10 -> 0x5A
    bus0.req0 = 1'b1; bus0.we0 = 1'b0; bus0.addr0 = 8'h10;
    tick();  // LOAD
    chk("rd_load_busy", bus0.busy,   1);
    chk("rd_load_we",   bus0.mbr_we, 0);
    chk("rd_load_rd",   bus0.mem_rd, 0);
    chk("rd_load_gnt",  bus0.gnt_id, 0);
    tick();  // ACCESS 1
    chk("rd_acc1_rd",   bus0.mem_rd,   1);
    chk("rd_acc1_addr", bus0.mem_addr, 8'h10);
    chk("rd_acc1_ack",  bus0.ack0,     0);
    tick();  // ACCESS 2
    chk("rd_acc2_rd",   bus0.mem_rd, 1);
    chk("rd_acc2_we",   bus0.mbr_we, 1);
    chk("rd_acc2_in",   bus0.mbr_in, 8'h5A);
    tick();  // DONE
    chk("rd_done_ack0", bus0.ack0,   1);
    chk("rd_done_ack1", bus0.ack1,   0);
    chk("rd_done_data", bus0.rdata,  8'h5A);
    chk("rd_done_rd",   bus0.mem_rd, 0);
    bus0.req0 = 1'b0;
    tick();
    chk("rd_after_ack", bus0.ack0, 0);
    chk("rd_after_busy", bus0.busy, 0);

    // Port 1 write of 0xC3 to 0x22
    bus0.req1 = 1'b1; bus0.we1 = 1'b1; bus0.addr1 = 8'h22; bus0.wdata1 = 8'hC3;
    tick();  // LOAD
    chk("wr_load_we",  bus0.mbr_we, 1);
    chk("wr_load_in",  bus0.mbr_in, 8'hC3);
    chk("wr_load_gnt", bus0.gnt_id, 1);
    tick();  // ACCESS 1
    chk("wr_acc1_wr",    bus0.mem_wr,    1);
    chk("wr_acc1_rd",    bus0.mem_rd,    0);
    chk("wr_acc1_wdata", bus0.mem_wdata, 8'hC3);
    chk("wr_acc1_addr",  bus0.mem_addr,  8'h22);
    tick();  // ACCESS 2
    chk("wr_acc2_wr",  bus0.mem_wr, 1);
    tick();  // DONE
    chk("wr_done_ack1", bus0.ack1,   1);
    chk("wr_done_ack0", bus0.ack0,   0);
    chk("wr_done_wr",   bus0.mem_wr, 0);
    bus0.req1 = 1'b0; bus0.we1 = 1'b0;
    tick();

    // Simultaneous requests: port 0 reads 0x31 (0x7B), port 1 reads 0x44 (0x0E)
    bus0.req0 = 1'b1; bus0.addr0 = 8'h31;
    bus0.req1 = 1'b1; bus0.addr1 = 8'h44;
`ifdef MBR_ARB_RR_EN
    for (int t = 0; t < 4; t++) begin
      wait_ack(p, n);
      chk("rr_port", p, t % 2);
      chk("rr_lat",  n, (t == 0) ? 4 : 5);
      chk("rr_data", bus0.rdata, (t % 2 == 0) ? 8'h7B : 8'h0E);
    end
    bus0.req0 = 1'b0; bus0.req1 = 1'b0;
`else
    wait_ack(p, n);
    chk("tie_first_port", p, 0);
    chk("tie_first_lat",  n, 4);
    chk("tie_first_data", bus0.rdata, 8'h7B);
    bus0.req0 = 1'b0;
    wait_ack(p, n);
    chk("tie_second_port", p, 1);
    chk("tie_second_lat",  n, 5);
    chk("tie_second_data", bus0.rdata, 8'h0E);
    bus0.req1 = 1'b0;
`endif
    tick();
    tick();

    // Reset during the second ACCESS cycle of a read
    bus0.req0 = 1'b1; bus0.we0 = 1'b0; bus0.addr0 = 8'h10;
    tick();  // LOAD
    tick();  // ACCESS 1
    tick();  // ACCESS 2
    chk("abort_acc2_rd", bus0.mem_rd, 1);
    rst = 1'b1;
    tick();
    chk("abort_busy", bus0.busy,   0);
    chk("abort_rd",   bus0.mem_rd, 0);
    chk("abort_ack",  {bus0.ack1, bus0.ack0}, 0);
    chk("abort_mbrwe", bus0.mbr_we, 0);
    rst = 1'b0;
    wait_ack(p, n);
    chk("rerun_port", p, 0);
    chk("rerun_lat",  n, 4);
    chk("rerun_data", bus0.rdata, 8'h5A);
    bus0.req0 = 1'b0;
    tick();

    // MEM_LAT=1 instance, port 0 read of 0x10
    bus1.req0 = 1'b1; bus1.we0 = 1'b0; bus1.addr0 = 8'h10;
    rdcnt = 0; ackat = 0; rd1 = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus1.mem_rd) rdcnt++;
      if (bus1.ack0 && ackat == 0) begin
        ackat = i;
        rd1 = bus1.rdata;
        bus1.req0 = 1'b0;
      end
    end
    chk("lat1_rd_cycles", rdcnt, 1);
    chk("lat1_ack_at",    ackat, 3);
    chk("lat1_data",      rd1,   8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mbr_arbiter.md
Name: mbr_arbiter

Overview:
- Memory-access sequencer that shares the single memory buffer register and memory port between two requesters: port 0 is instruction fetch, port 1 is the data/execute unit.
- Latches the winner's address, direction and write data.
- Drives the MBR write-enable and input mux, and holds the memory read/write strobe for a fixed latency.
- Returns a one-cycle acknowledge with read data taken from the MBR output.

Parameters:
- AW, 8, address width.
- DW, 8, data width; matches the MBR.
- MEM_LAT, 2, memory access cycles with the strobe held; legal range 1..15.

Ports:
- mbr_arbiter_clk  in  1  system clock, rising edge.
- mbr_arbiter_rst  in  1  reset; synchronous, active-high.
- req0  in  1  port 0 request.
- we0  in  1  port 0 direction: 1 = write, 0 = read.
- addr0  in  AW  port 0 address.
- wdata0  in  DW  port 0 write data.
- ack0  out  1  port 0 transaction complete, one-cycle pulse.
- req1, we1, addr1, wdata1, ack1  same as port 0, for port 1.
- rdata  out  DW  read data, equal to mbr_out; valid while ackN=1 on a read.
- mbr_we  out  1  MBR write enable.
- mbr_in  out  DW  MBR input data.
- mbr_out  in  DW  current MBR contents.
- mem_addr  out  AW  latched transaction address.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  DW  memory write data, equal to mbr_out.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high in any state other than IDLE.
- gnt_id  out  1  index of the current or last granted port.

Behaviour:
- Clock and reset: one clock, mbr_arbiter_clk. mbr_arbiter_rst is synchronous and active-high.
- Reset values: state=IDLE; ack0, ack1, mbr_we, mem_rd, mem_wr, busy = 0; mem_addr=0; gnt_id=1; lat_cnt=0. MBR contents are not touched by reset.
- States: IDLE, LOAD, ACCESS, DONE. All outputs except rdata, mem_wdata and mbr_in are registered or decoded from state only.
- IDLE:
  - If req0 or req1 is high at the edge: select a winner, latch its addr/we/wdata, set gnt_id, go to LOAD.
  - Otherwise stay in IDLE.
  - The loser's req is ignored and must remain asserted to be served later.
- LOAD (1 cycle):
  - Write: mbr_we=1, mbr_in=latched wdata.
  - Read: mbr_we=0.
  - lat_cnt <= MEM_LAT-1; go to ACCESS.
- ACCESS (MEM_LAT cycles):
  - mem_rd or mem_wr held high for the whole state; mem_addr stable.
  - lat_cnt decrements each cycle.
  - Read, on the cycle with lat_cnt==0: mbr_we=1, mbr_in=mem_rdata (sampled in that cycle).
  - Go to DONE when lat_cnt==0.
- DONE (1 cycle):
  - ack[gnt_id]=1; strobes low. For reads, rdata holds the new MBR value.
  - Requests are not sampled in DONE. Go to IDLE.
- Latency: request sampled at edge k; ack high during cycle k+2+MEM_LAT, which is cycle k+4 with the default MEM_LAT.
- Requester contract: deassert req in the cycle after ack. A req still high in IDLE starts a new transaction.
- Arbitration (default): fixed priority, port 0 wins. Simultaneous requests are served back to back with one IDLE cycle between them.
- mbr_in mux: wdata in LOAD, mem_rdata in ACCESS, don't-care elsewhere (drive 0).
- Reset mid-operation: returns to IDLE on the same edge. Strobes and ack drop at once; no ack is issued for the aborted transaction. The MBR may hold partial data.
- mem_rd and mem_wr are never high together. At most one ack is high in any cycle.

Optional Feature:
- Macro: MBR_ARB_RR_EN.
- When defined: round-robin arbitration. On simultaneous requests the port not equal to the last granted port wins. Because gnt_id resets to 1, port 0 wins the first tie. gnt_id updates at each grant.
- When undefined: fixed priority, port 0 always wins. The round-robin logic is absent.

Test Plan (MEM_LAT=2):
- Port 0 read, addr0=0x10, memory returns 0x5A: mem_rd high for exactly 2 cycles with mem_addr=0x10 -> ack0 at req edge+4, rdata=0x5A, ack1=0.
- Port 1 write, addr1=0x22, wdata1=0xC3: mbr_we pulses in LOAD with mbr_in=0xC3 -> mem_wr high 2 cycles, mem_wdata=0xC3 -> ack1 at edge+4.
- req0 and req1 both high on the same edge, no macro: port 0 acked at edge+4, port 1 acked at edge+9, with one IDLE cycle between transactions.
- Same stimulus with MBR_ARB_RR_EN defined, repeated twice while both requests stay asserted: grant order 0, 1, 0, 1.
- Reset asserted during the 2nd ACCESS cycle of a read: next cycle state=IDLE, mem_rd=0, no ack, busy=0. A new req0 then completes normally.
- MEM_LAT=1 build, port 0 read: mem_rd high for 1 cycle, ack0 at edge+3.
